// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster pipeline: default 640x480 timing,
// test-pattern mode encodings, colour-bar table and the per-pixel flag bundle.
package vga_pkg;

  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;

  typedef enum logic [1:0] {
    PAT_PASS  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_BLACK = 2'd3
  } pat_mode_e;

  // One bit per channel {R,G,B}; bar 0 (left edge) is the rightmost entry.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } vga_flags_t;

endpackage

// File: rtl/vga_timing_pipe_if.sv
// Frame-RAM read port plus the registered video bundle toward image_process / DAC.
interface vga_timing_pipe_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 19
);
  // pix_data must carry the RAM word for the pix_addr presented exactly RD_LAT cycles
  // earlier; there is no valid/ready, the scan never stalls. All video outputs are
  // registered and mutually aligned to vga_data.
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;
  logic              hs;
  logic              vs;
  logic              de;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              frame_start;
  logic [DATA_W-1:0] vga_data;

  modport master (
    output pix_addr, hs, vs, de, pos_x, pos_y, frame_start, vga_data,
    input  pix_data
  );

  modport slave (
    input  pix_addr, hs, vs, de, pos_x, pos_y, frame_start, vga_data,
    output pix_data
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern source: colour bars, 32-pixel grid or black, by (x, y).
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int DATA_W   = 12
) (
  input  pat_mode_e         mode,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [DATA_W-1:0] pix
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int CH_W  = DATA_W / 3;

  logic [2:0] bar_idx;
  logic [2:0] rgb;

  always_comb begin
    bar_idx = '0;
    // Threshold compare instead of a divider: bar index = number of boundaries passed.
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(i * BAR_W)) bar_idx = 3'(i);
    end

    rgb = 3'b000;
    case (mode)
      PAT_BARS: rgb = BAR_RGB[bar_idx];
      PAT_GRID: rgb = ((x[4:0] == 5'd0) || (y[4:0] == 5'd0)) ? 3'b111 : 3'b000;
      default:  rgb = 3'b000;
    endcase

    pix = '0;
    pix[DATA_W-1        -: CH_W] = {CH_W{rgb[2]}};
    pix[DATA_W-1-CH_W   -: CH_W] = {CH_W{rgb[1]}};
    pix[DATA_W-1-2*CH_W -: CH_W] = {CH_W{rgb[0]}};
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster generator: counters, look-ahead RAM addressing, flag delay line
// matching the RAM latency, and the registered pass-through / test-pattern output mux.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RD_LAT   = 2,
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 19
) (
  input  logic                vga_clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          pattern_mode,
  vga_timing_pipe_if.master   bus
);

  localparam int H_TOT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HCNT_W = $clog2(H_TOT);
  localparam int VCNT_W = $clog2(V_TOT);

  localparam logic [HCNT_W-1:0] H_LAST      = HCNT_W'(H_TOT - 1);
  localparam logic [HCNT_W-1:0] H_SYNC_END  = HCNT_W'(H_SYNC);
  localparam logic [HCNT_W-1:0] H_ACT_START = HCNT_W'(H_SYNC + H_BP);
  localparam logic [HCNT_W-1:0] H_ACT_END   = HCNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] V_LAST      = VCNT_W'(V_TOT - 1);
  localparam logic [VCNT_W-1:0] V_SYNC_END  = VCNT_W'(V_SYNC);
  localparam logic [VCNT_W-1:0] V_ACT_START = VCNT_W'(V_SYNC + V_BP);
  localparam logic [VCNT_W-1:0] V_ACT_END   = VCNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

  localparam vga_flags_t FLAGS_IDLE = '{hs: !HS_POL, vs: !VS_POL, de: 1'b0, fs: 1'b0,
                                        x: 10'd0, y: 10'd0};

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  pat_mode_e         mode_q, mode_d;
  vga_flags_t        pipe_q [RD_LAT+1];
  vga_flags_t        pipe_d [RD_LAT+1];
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic [DATA_W-1:0] pat_pix;

  logic       h_wrap, v_wrap, h_act, v_act, de0, last_pix;
  vga_flags_t st0;

  always_comb begin
    h_wrap   = (hcnt_q == H_LAST);
    v_wrap   = h_wrap && (vcnt_q == V_LAST);
    h_act    = (hcnt_q >= H_ACT_START) && (hcnt_q <= H_ACT_END);
    v_act    = (vcnt_q >= V_ACT_START) && (vcnt_q <= V_ACT_END);
    de0      = en && h_act && v_act;
    last_pix = de0 && (hcnt_q == H_ACT_END) && (vcnt_q == V_ACT_END);

    // Stage 0 is the raster position whose address is on pix_addr this cycle.
    st0    = FLAGS_IDLE;
    st0.hs = (en && (hcnt_q < H_SYNC_END)) ? HS_POL : !HS_POL;
    st0.vs = (en && (vcnt_q < V_SYNC_END)) ? VS_POL : !VS_POL;
    st0.de = de0;
    st0.fs = de0 && (hcnt_q == H_ACT_START) && (vcnt_q == V_ACT_START);
    st0.x  = de0 ? 10'(hcnt_q - H_ACT_START) : 10'd0;
    st0.y  = de0 ? 10'(vcnt_q - V_ACT_START) : 10'd0;
  end

  always_comb begin
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    pix_addr_d = pix_addr_q;
    mode_d     = mode_q;
    if (!en) begin
      hcnt_d     = '0;
      vcnt_d     = '0;
      pix_addr_d = '0;
      mode_d     = pat_mode_e'(pattern_mode);
    end else begin
      hcnt_d = h_wrap ? '0 : hcnt_q + HCNT_W'(1);
      if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + VCNT_W'(1);
      // Mode only changes between frames so a frame is never torn.
      if (v_wrap) begin
        pix_addr_d = '0;
        mode_d     = pat_mode_e'(pattern_mode);
      end else if (de0) begin
        pix_addr_d = last_pix ? '0 : pix_addr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    pipe_d[0] = st0;
    for (int k = 1; k <= RD_LAT; k++) pipe_d[k] = pipe_q[k-1];
  end

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .DATA_W   (DATA_W)
  ) u_pattern_gen (
    .mode (mode_q),
    .x    (pipe_q[RD_LAT-1].x),
    .y    (pipe_q[RD_LAT-1].y),
    .pix  (pat_pix)
  );

  // Tap one stage early so the registered pixel lines up with the last flag stage.
  always_comb begin
    vga_data_d = '0;
    if (pipe_q[RD_LAT-1].de) vga_data_d = (mode_q == PAT_PASS) ? bus.pix_data : pat_pix;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      pix_addr_q <= '0;
      mode_q     <= PAT_PASS;
      vga_data_q <= '0;
      for (int k = 0; k <= RD_LAT; k++) pipe_q[k] <= FLAGS_IDLE;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      pix_addr_q <= pix_addr_d;
      mode_q     <= mode_d;
      vga_data_q <= vga_data_d;
      for (int k = 0; k <= RD_LAT; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign bus.pix_addr    = pix_addr_q;
  assign bus.hs          = pipe_q[RD_LAT].hs;
  assign bus.vs          = pipe_q[RD_LAT].vs;
  assign bus.de          = pipe_q[RD_LAT].de;
  assign bus.frame_start = pipe_q[RD_LAT].fs;
  assign bus.pos_x       = pipe_q[RD_LAT].x;
  assign bus.pos_y       = pipe_q[RD_LAT].y;
  assign bus.vga_data    = vga_data_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench on a reduced 73x46 raster: two DUTs (active-low syncs / RD_LAT=2 and
// active-high syncs / RD_LAT=4) share the controls; each reads a RAM model returning data=addr.
module tb_vga_timing_pipe;

  localparam int HS = 4, HB = 3, HA = 64, HF = 2;
  localparam int VS = 2, VB = 2, VA = 40, VF = 2;
  localparam int H_TOT = HS + HB + HA + HF;   // 73
  localparam int V_TOT = VS + VB + VA + VF;   // 46
  localparam int FRAME = H_TOT * V_TOT;       // 3358
  localparam int W = 40;

  logic       vga_clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] pattern_mode;
  int         cyc = 0;

  // ---------------- clock / reset block ----------------
  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  vga_timing_pipe_if #(.DATA_W(12), .ADDR_W(12)) bus_a ();
  vga_timing_pipe_if #(.DATA_W(12), .ADDR_W(12)) bus_b ();

  vga_timing_pipe #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2), .DATA_W(12), .ADDR_W(12)
  ) dut_a (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en), .pattern_mode(pattern_mode), .bus(bus_a)
  );

  vga_timing_pipe #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(4), .DATA_W(12), .ADDR_W(12)
  ) dut_b (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en), .pattern_mode(pattern_mode), .bus(bus_b)
  );

  // RAM models: data = address, returned RD_LAT cycles later.
  logic [11:0] ram_a [2];
  logic [11:0] ram_b [4];
  always @(posedge vga_clk) begin
    ram_a[0] <= bus_a.pix_addr;
    ram_a[1] <= ram_a[0];
    ram_b[0] <= bus_b.pix_addr;
    for (int k = 1; k < 4; k++) ram_b[k] <= ram_b[k-1];
  end
  assign bus_a.pix_data = ram_a[1];
  assign bus_b.pix_data = ram_b[3];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qb[$];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] model_pix(input int mode, input int x, input int y);
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    case (mode)
      0:       return 12'(y * HA + x);
      1:       return bars[x / (HA / 8)];
      2:       return ((x % 32 == 0) || (y % 32 == 0)) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [W-1:0] pack_obs(input logic fs, input logic [9:0] y,
                                            input logic [9:0] x, input logic [11:0] d);
    return {7'd0, fs, y, x, d};
  endfunction

  // ---------------- monitor ----------------
  logic chk_on = 1'b0, meas_on = 1'b0;
  int   hs_cnt_a = 0, vs_cnt_a = 0, de_cnt_a = 0;
  int   hs_cnt_b = 0, vs_cnt_b = 0, de_cnt_b = 0;
  int   hs_edge_a[$], hs_edge_b[$], vs_edge_a[$], vs_edge_b[$];
  int   last_fs_a = 0, last_fs_b = 0;
  logic prev_hs_a = 1'b1, prev_hs_b = 1'b0, prev_vs_a = 1'b1, prev_vs_b = 1'b0;
  logic [W-1:0] exp_w;

  always @(negedge vga_clk) begin
    if (bus_a.frame_start) last_fs_a = cyc;
    if (bus_b.frame_start) last_fs_b = cyc;
    if (chk_on) begin
      if (bus_a.de) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check_eq("a_pix", pack_obs(bus_a.frame_start, bus_a.pos_y, bus_a.pos_x, bus_a.vga_data), exp_w);
      end else begin
        check_eq("a_idle", pack_obs(bus_a.frame_start, bus_a.pos_y, bus_a.pos_x, bus_a.vga_data), '0);
      end
      if (bus_b.de) begin
        exp_w = (exp_qb.size() != 0) ? exp_qb.pop_front() : '1;
        check_eq("b_pix", pack_obs(bus_b.frame_start, bus_b.pos_y, bus_b.pos_x, bus_b.vga_data), exp_w);
      end else begin
        check_eq("b_idle", pack_obs(bus_b.frame_start, bus_b.pos_y, bus_b.pos_x, bus_b.vga_data), '0);
      end
      if (!bus_a.vs && prev_vs_a) vs_edge_a.push_back(cyc);
      if (bus_b.vs && !prev_vs_b) vs_edge_b.push_back(cyc);
    end
    if (meas_on) begin
      if (!bus_a.hs) hs_cnt_a++;
      if (!bus_a.vs) vs_cnt_a++;
      if (bus_a.de)  de_cnt_a++;
      if (bus_b.hs)  hs_cnt_b++;
      if (bus_b.vs)  vs_cnt_b++;
      if (bus_b.de)  de_cnt_b++;
      if (!bus_a.hs && prev_hs_a) hs_edge_a.push_back(cyc);
      if (bus_b.hs && !prev_hs_b) hs_edge_b.push_back(cyc);
    end
    prev_hs_a = bus_a.hs; prev_hs_b = bus_b.hs;
    prev_vs_a = bus_a.vs; prev_vs_b = bus_b.vs;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic push_frame(input int mode);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        exp_q.push_back(pack_obs((x == 0) && (y == 0), 10'(y), 10'(x), model_pix(mode, x, y)));
        exp_qb.push_back(pack_obs((x == 0) && (y == 0), 10'(y), 10'(x), model_pix(mode, x, y)));
      end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_a"}, {34'd0, bus_a.hs, bus_a.vs, bus_a.de, bus_a.frame_start, 2'd0},
             {34'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
    check_eq({tag, "_a_data"}, pack_obs(1'b0, bus_a.pos_y, bus_a.pos_x, bus_a.vga_data), '0);
    check_eq({tag, "_b"}, {34'd0, bus_b.hs, bus_b.vs, bus_b.de, bus_b.frame_start, 2'd0},
             {34'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
    check_eq({tag, "_b_data"}, pack_obs(1'b0, bus_b.pos_y, bus_b.pos_x, bus_b.vga_data), '0);
  endtask

  int c0, c_off, c_on, c_r;

  initial begin
    rst_n = 1'b0; en = 1'b0; pattern_mode = 2'd0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    check_idle("reset");
    check_eq("reset_addr_a", W'(bus_a.pix_addr), '0);
    check_eq("reset_addr_b", W'(bus_b.pix_addr), '0);

    @(posedge vga_clk); #1; rst_n = 1'b1;
    repeat (4) @(posedge vga_clk);
    push_frame(0); push_frame(1); push_frame(2);

    @(posedge vga_clk); #1;
    en = 1'b1; c0 = cyc; chk_on = 1'b1; meas_on = 1'b1;

    wait_cyc(c0 + 304); @(negedge vga_clk);
    check_eq("addr_row0_x5", W'(bus_a.pix_addr), W'(5));
    wait_cyc(c0 + 364); @(negedge vga_clk);
    check_eq("addr_hold_blank", W'(bus_a.pix_addr), W'(64));
    wait_cyc(c0 + 1000); pattern_mode = 2'd1;
    wait_cyc(c0 + 3209); @(negedge vga_clk);
    check_eq("addr_max", W'(bus_a.pix_addr), W'(HA * VA - 1));
    wait_cyc(c0 + 3210); @(negedge vga_clk);
    check_eq("addr_wrap", W'(bus_a.pix_addr), '0);

    wait_cyc(c0 + FRAME); meas_on = 1'b0;
    check_eq("hs_active_a", W'(hs_cnt_a), W'(HS * V_TOT));
    check_eq("vs_active_a", W'(vs_cnt_a), W'(VS * H_TOT));
    check_eq("de_count_a",  W'(de_cnt_a), W'(HA * VA));
    check_eq("hs_active_b", W'(hs_cnt_b), W'(HS * V_TOT));
    check_eq("vs_active_b", W'(vs_cnt_b), W'(VS * H_TOT));
    check_eq("de_count_b",  W'(de_cnt_b), W'(HA * VA));
    check_eq("hs_period_a", W'((hs_edge_a.size() > 1) ? hs_edge_a[1] - hs_edge_a[0] : 0), W'(H_TOT));
    check_eq("hs_period_b", W'((hs_edge_b.size() > 1) ? hs_edge_b[1] - hs_edge_b[0] : 0), W'(H_TOT));
    check_eq("fs_lat_a", W'(last_fs_a - c0), W'((VS + VB) * H_TOT + HS + HB + 3));
    check_eq("fs_lat_b", W'(last_fs_b - c0), W'((VS + VB) * H_TOT + HS + HB + 5));

    wait_cyc(c0 + FRAME + 1000); pattern_mode = 2'd2;
    wait_cyc(c0 + 3 * FRAME + 10); chk_on = 1'b0;
    check_eq("exp_left_a", W'(exp_q.size()), '0);
    check_eq("exp_left_b", W'(exp_qb.size()), '0);
    check_eq("vs_period_a", W'((vs_edge_a.size() > 1) ? vs_edge_a[1] - vs_edge_a[0] : 0), W'(FRAME));
    check_eq("vs_period_b", W'((vs_edge_b.size() > 1) ? vs_edge_b[1] - vs_edge_b[0] : 0), W'(FRAME));

    // Drop en in the middle of an active line of frame 3.
    wait_cyc(c0 + 3 * FRAME + 329);
    en = 1'b0; c_off = cyc;
    wait_cyc(c_off + 1); @(negedge vga_clk);
    check_eq("en_low_addr", W'(bus_a.pix_addr), '0);
    wait_cyc(c_off + 6); @(negedge vga_clk);
    check_idle("en_low");
    pattern_mode = 2'd1;
    wait_cyc(c_off + 100);
    last_fs_a = 0; last_fs_b = 0;
    en = 1'b1; c_on = cyc;
    wait_cyc(c_on + 310); @(negedge vga_clk);
    check_eq("restart_fs_a", W'(last_fs_a - c_on), W'((VS + VB) * H_TOT + HS + HB + 3));
    check_eq("restart_fs_b", W'(last_fs_b - c_on), W'((VS + VB) * H_TOT + HS + HB + 5));
    check_eq("restart_bars_a", pack_obs(1'b0, bus_a.pos_y, bus_a.pos_x, bus_a.vga_data),
             pack_obs(1'b0, 10'd0, 10'd8, 12'hFF0));
    check_eq("restart_bars_b", pack_obs(1'b0, bus_b.pos_y, bus_b.pos_x, bus_b.vga_data),
             pack_obs(1'b0, 10'd0, 10'd6, 12'hFFF));

    // Asynchronous reset pulse mid-frame, between clock edges.
    wait_cyc(c_on + 600);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check_eq("async_rst_addr", W'(bus_a.pix_addr), '0);
    @(posedge vga_clk); #1;
    last_fs_a = 0; last_fs_b = 0;
    rst_n = 1'b1; c_r = cyc;
    wait_cyc(c_r + 310); @(negedge vga_clk);
    check_eq("rst_fs_a", W'(last_fs_a - c_r), W'((VS + VB) * H_TOT + HS + HB + 3));
    check_eq("rst_fs_b", W'(last_fs_b - c_r), W'((VS + VB) * H_TOT + HS + HB + 5));
    check_eq("rst_mode_pass_a", pack_obs(1'b0, bus_a.pos_y, bus_a.pos_x, bus_a.vga_data),
             pack_obs(1'b0, 10'd0, 10'd8, 12'd8));
    check_eq("rst_mode_pass_b", pack_obs(1'b0, bus_b.pos_y, bus_b.pos_x, bus_b.vga_data),
             pack_obs(1'b0, 10'd0, 10'd6, 12'd6));

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
